gray_counter_bank: RTL
======================

Name: gray_counter_bank

Overview:
- Bank of NUM_CH independent Gray-coded counters of WIDTH bits with one shared update port and one read port.
- Each counter counts up or down and supports a direct Gray-value load.
- Used by the cache control path as per-set round-robin victim pointers and as Gray-coded occupancy pointers.
- Generalises the single up-only Gray counter to multiple channels, bidirectional counting, load, and wrap reporting.

Parameters:
- WIDTH, 2: bits per counter; legal range 1..16. WIDTH=1 makes the Gray and binary values identical.
- NUM_CH, 4: number of counters; legal range 1..256. Need not be a power of two.

Ports:
- clk  in  1  rising-edge clock.
- not_reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  in  1  count enable for channel ch.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- ch  in  SEL_W  channel addressed by en and load.
- load  in  1  load load_gray into channel ch.
- load_gray  in  WIDTH  Gray-coded load value.
- rd_ch  in  SEL_W  channel selected for reading.
- rd_value  out  WIDTH  Gray value of channel rd_ch.
- rd_bin  out  WIDTH  binary equivalent of rd_value.
- wrap  out  1  registered one-cycle pulse on a wrap of the updated channel.

Behaviour:
- SEL_W = max(1, clog2(NUM_CH)); it is a localparam.
- State: NUM_CH binary registers cnt[i]. Gray is derived as g = b ^ (b >> 1). Only state is registered; rd_value and rd_bin are combinational from state.
- Reset (not_reset=0 at a rising edge): every cnt = 0, wrap = 0. Reset overrides load and en in the same cycle. Asserting reset mid-sequence discards any pending update.
- Priority per edge, when not_reset=1:
  - load=1: cnt[ch] <= gray2bin(load_gray); en is ignored; wrap <= 0.
  - else en=1, up=1: cnt[ch] <= cnt[ch]+1 mod 2^WIDTH.
  - else en=1, up=0: cnt[ch] <= cnt[ch]-1 mod 2^WIDTH.
  - else: hold all counters; wrap <= 0.
- wrap <= 1 for one cycle when:
  - an up-count moves cnt[ch] from 2^WIDTH-1 to 0, or
  - a down-count moves cnt[ch] from 0 to 2^WIDTH-1.
  - Otherwise wrap <= 0.
- Only channel ch can change in a cycle; all other channels hold.
- Out-of-range ch (ch >= NUM_CH): load and en have no effect; wrap <= 0.
- Out-of-range rd_ch: rd_value = 0 and rd_bin = 0.
- Latency:
  - An update at edge N is visible on rd_value from edge N onward (same-cycle read shows the old value).
  - wrap is asserted in the cycle following the wrapping edge's update, aligned with the new value.
- gray2bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Successive values of any channel differ in exactly one Gray bit, except after a load.

Optional Feature:
- Macro: GRAY_BANK_SATURATE_EN.
- Defined:
  - An up-count at 2^WIDTH-1 holds the value.
  - A down-count at 0 holds the value.
  - wrap pulses for one cycle to flag the blocked step.
  - Load is unaffected.
- Undefined: modular wrap-around as described in Behaviour.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray and gray2bin, parameterised through WIDTH-sized arguments;
  - constant GRAY_MAX_WIDTH = 16.
- Sub-module gray_counter_channel holds one binary register, the next-value/wrap logic, and the saturate option. It is instantiated NUM_CH times by a generate loop.
- The top level holds:
  - channel decode of ch;
  - the wrap register (OR of per-channel wrap strobes);
  - the read multiplexer with Gray and binary conversion.

Test Plan:
(All scenarios use WIDTH=3, NUM_CH=4 unless stated.)
1. Reset, then eight en=1/up=1 cycles on ch=1, with rd_ch=1 -> rd_value sequence 0,1,3,2,6,7,5,4,0. wrap=1 only in the cycle after the 8th enable. Channels 0, 2 and 3 read 0 throughout.
2. After reset, one en=1/up=0 cycle on ch=2 -> rd_value=3'b100, rd_bin=7, wrap=1 for one cycle. A further down step gives 3'b101 and wrap=0.
3. load=1, load_gray=3'b110, en=1, up=1 on ch=3 in the same cycle -> rd_value=3'b110, rd_bin=4, wrap=0. The next up step gives 3'b111.
4. Count ch=0 to 3'b010, then drive not_reset=0 for one edge while en=1 -> all channels read 0 and wrap=0. Counting resumes from 0 next cycle.
5. NUM_CH=3 build: en=1 with ch=3, then rd_ch=3 -> no channel changes, wrap=0, rd_value=0.
6. GRAY_BANK_SATURATE_EN build: load 3'b100 (bin 7), then up step -> value stays 3'b100 and wrap pulses once. A down step then gives 3'b101.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gray_pkg                                                |
// | Purpose  : Gray/binary conversion helpers shared by the Gray bank  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package gray_pkg;

   localparam int GRAY_MAX_WIDTH = 16;

   // Arguments are zero-extended to GRAY_MAX_WIDTH. Callers truncate the result back.
   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
      logic [GRAY_MAX_WIDTH-1:0] bin;
      bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
      for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gray_counter_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gray_counter_channel                                    |
// | Purpose  : One binary counter of the Gray bank, with up/down/load  |
// |            and wrap strobe. GRAY_BANK_SATURATE_EN: clamp at ends.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module gray_counter_channel #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             not_reset,
   input  logic             sel,
   input  logic             load,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap_strobe
);

   localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_cnt_min = {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

   always_comb begin
      w_next = r_cnt;
      w_wrap = 1'b0;
      if (sel) begin
         if (load) begin
            w_next = load_bin;
         end else if (en) begin
            if (up) begin
               w_wrap = (r_cnt == c_cnt_max);
`ifdef GRAY_BANK_SATURATE_EN
               if (!w_wrap) w_next = r_cnt + 1'b1;
`else
               w_next = r_cnt + 1'b1;
`endif
            end else begin
               w_wrap = (r_cnt == c_cnt_min);
`ifdef GRAY_BANK_SATURATE_EN
               if (!w_wrap) w_next = r_cnt - 1'b1;
`else
               w_next = r_cnt - 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!not_reset) r_cnt <= '0;
      else            r_cnt <= w_next;
   end

   assign cnt         = r_cnt;
   assign wrap_strobe = w_wrap;

endmodule
`default_nettype wire

// File: rtl/gray_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gray_counter_bank                                       |
// | Purpose  : NUM_CH Gray counters, shared update port, one read port |
// |            Option macro: GRAY_BANK_SATURATE_EN (clamp, no wrap).   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module gray_counter_bank
   import gray_pkg::*;
#(
   parameter  int WIDTH  = 2,
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             not_reset,
   input  logic             en,
   input  logic             up,
   input  logic [SEL_W-1:0] ch,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   input  logic [SEL_W-1:0] rd_ch,
   output logic [WIDTH-1:0] rd_value,
   output logic [WIDTH-1:0] rd_bin,
   output logic             wrap
);

   logic [NUM_CH-1:0] w_sel;
   logic [NUM_CH-1:0] w_wrap_strobe;
   logic [WIDTH-1:0]  w_cnt [NUM_CH];
   logic [WIDTH-1:0]  w_load_bin;
   logic [WIDTH-1:0]  w_rd_bin;
   logic              r_wrap;

   // Convert once here so every channel shares a single gray2bin tree.
   assign w_load_bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(load_gray)));

   genvar i;
   for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_sel[i] = (ch == SEL_W'(i));

      gray_counter_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .clk         (clk),
         .not_reset   (not_reset),
         .sel         (w_sel[i]),
         .load        (load),
         .en          (en),
         .up          (up),
         .load_bin    (w_load_bin),
         .cnt         (w_cnt[i]),
         .wrap_strobe (w_wrap_strobe[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!not_reset) r_wrap <= 1'b0;
      else            r_wrap <= |w_wrap_strobe;
   end

   // Out-of-range rd_ch matches no channel and reads as zero.
   always_comb begin
      w_rd_bin = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch == SEL_W'(k)) w_rd_bin = w_cnt[k];
      end
   end

   assign rd_bin   = w_rd_bin;
   assign rd_value = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_rd_bin)));
   assign wrap     = r_wrap;

endmodule
`default_nettype wire
